// File: rtl/word_unpack_reader.sv
// word_unpack_reader: accepts a packed word {a[1:0], b[1:0], m0[3:0], m1[3:0]}
// (zero-extended), latches its decoded fields and streams the whole word out
// as 4-bit nibbles, most-significant nibble first.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready; in_ready may depend on out_ready (it is high
// in STREAM only while the last nibble is being handed off), which lets a new
// word load on the same edge as the last nibble with no bubble.
module word_unpack_reader #(
  parameter int NIBBLES = 8,
  parameter int IDXW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_nibble,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic [1:0]           fld_a,
  output logic [1:0]           fld_b,
  output logic [3:0]           fld_m0,
  output logic [3:0]           fld_m1,
  output logic                 a_gt_b,
  output logic                 hi_nonzero,
  output logic                 dbg_state
);

  localparam int W = 4 * NIBBLES;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NIBBLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [1:0]      fld_a_q, fld_a_d;
  logic [1:0]      fld_b_q, fld_b_d;
  logic [3:0]      fld_m0_q, fld_m0_d;
  logic [3:0]      fld_m1_q, fld_m1_d;
  logic            a_gt_b_q, a_gt_b_d;
  logic            hi_nonzero_q, hi_nonzero_d;

  logic            hi_bits;
  logic            accept;
  logic [3:0]      nib_sel;

  // Bits above the packed fields only exist when the word is wider than 12.
  if (NIBBLES > 3) begin : g_hi
    assign hi_bits = |in_data[W-1:12];
  end else begin : g_no_hi
    assign hi_bits = 1'b0;
  end

  // Select the nibble addressed by the current index.
  always_comb begin
    nib_sel = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) nib_sel = word_q[4*i +: 4];
    end
  end

  // Handshake outputs; nibble and last are forced low outside STREAM.
  always_comb begin
    out_valid  = (state_q == STREAM);
    out_last   = out_valid && (idx_q == '0);
    in_ready   = !out_valid || (out_last && out_ready);
    out_nibble = out_valid ? nib_sel : 4'h0;
    out_idx    = idx_q;
    accept     = in_valid && in_ready;
    dbg_state  = state_q;
    fld_a      = fld_a_q;
    fld_b      = fld_b_q;
    fld_m0     = fld_m0_q;
    fld_m1     = fld_m1_q;
    a_gt_b     = a_gt_b_q;
    hi_nonzero = hi_nonzero_q;
  end

  // Next-state logic: index countdown, reload on accept, fields on accept.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    fld_a_d      = fld_a_q;
    fld_b_d      = fld_b_q;
    fld_m0_d     = fld_m0_q;
    fld_m1_d     = fld_m1_q;
    a_gt_b_d     = a_gt_b_q;
    hi_nonzero_d = hi_nonzero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          idx_d   = IDX_TOP;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (in_valid) begin
            idx_d = IDX_TOP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      word_d       = in_data;
      fld_a_d      = in_data[11:10];
      fld_b_d      = in_data[9:8];
      fld_m0_d     = in_data[7:4];
      fld_m1_d     = in_data[3:0];
      a_gt_b_d     = (in_data[11:10] > in_data[9:8]);
      hi_nonzero_d = hi_bits;
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      fld_a_q      <= '0;
      fld_b_q      <= '0;
      fld_m0_q     <= '0;
      fld_m1_q     <= '0;
      a_gt_b_q     <= 1'b0;
      hi_nonzero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      fld_a_q      <= fld_a_d;
      fld_b_q      <= fld_b_d;
      fld_m0_q     <= fld_m0_d;
      fld_m1_q     <= fld_m1_d;
      a_gt_b_q     <= a_gt_b_d;
      hi_nonzero_q <= hi_nonzero_d;
    end
  end

endmodule

// File: tb/tb_word_unpack_reader.sv
// Testbench for word_unpack_reader: an 8-nibble instance for the main
// scenarios and a 3-nibble instance for the narrow-parameter case.
module tb_word_unpack_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 8-nibble DUT ----------------
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data;
  logic [3:0]  out_nibble, fld_m0, fld_m1;
  logic [3:0]  out_idx;
  logic [1:0]  fld_a, fld_b;
  logic        a_gt_b, hi_nonzero, dbg_state;

  word_unpack_reader #(.NIBBLES(8), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_nibble(out_nibble),
    .out_idx(out_idx), .out_last(out_last),
    .fld_a(fld_a), .fld_b(fld_b), .fld_m0(fld_m0), .fld_m1(fld_m1),
    .a_gt_b(a_gt_b), .hi_nonzero(hi_nonzero), .dbg_state(dbg_state)
  );

  // ---------------- 3-nibble DUT ----------------
  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_last3;
  logic [11:0] in_data3;
  logic [3:0]  out_nibble3, fld_m0_3, fld_m1_3;
  logic [1:0]  out_idx3, fld_a3, fld_b3;
  logic        a_gt_b3, hi_nonzero3, dbg_state3;

  word_unpack_reader #(.NIBBLES(3), .IDXW(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_nibble(out_nibble3),
    .out_idx(out_idx3), .out_last(out_last3),
    .fld_a(fld_a3), .fld_b(fld_b3), .fld_m0(fld_m0_3), .fld_m1(fld_m1_3),
    .a_gt_b(a_gt_b3), .hi_nonzero(hi_nonzero3), .dbg_state(dbg_state3)
  );

  // ---------------- scoreboard ----------------
  // Queue item format: {last, idx[3:0], nibble[3:0]}
  logic [8:0] exp_q[$];
  logic [8:0] exp3_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int n, input bit narrow);
    for (int i = n - 1; i >= 0; i--) begin
      if (narrow) exp3_q.push_back({(i == 0), 4'(i), w[4*i +: 4]});
      else        exp_q.push_back({(i == 0), 4'(i), w[4*i +: 4]});
    end
  endtask

  // Monitor for the 8-nibble DUT: pops on every nibble handshake and
  // checks that a stalled nibble stays put until it is taken.
  logic       hold_v = 1'b0;
  logic [8:0] hold_item;
  always @(negedge clk) begin
    logic [8:0] act, item;
    act = {out_last, out_idx, out_nibble};
    if (rst_n && out_valid) begin
      chk("in_ready_in_stream", in_ready, out_last && out_ready);
      if (hold_v) chk("hold_stable", act, hold_item);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_nibble: got %0h, required no output", act);
        end else begin
          item = exp_q.pop_front();
          chk("nibble", act, item);
        end
        hold_v = 1'b0;
      end else begin
        hold_v    = 1'b1;
        hold_item = act;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Monitor for the 3-nibble DUT.
  always @(negedge clk) begin
    logic [8:0] act, item;
    act = {out_last3, 2'b00, out_idx3, out_nibble3};
    if (rst_n && out_valid3 && out_ready3) begin
      if (exp3_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_nibble3: got %0h, required no output", act);
      end else begin
        item = exp3_q.pop_front();
        chk("nibble3", act, item);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] w);
    bit acc = 0;
    push_word(w, 8, 0);
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0;
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_word3(input logic [11:0] w);
    bit acc = 0;
    push_word({20'h0, w}, 3, 1);
    in_valid3 = 1'b1;
    in_data3  = w;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready3) begin
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      chk("accept3_timeout", 0, 1);
      in_valid3 = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!out_valid && !out_valid3) break;
    end
    chk(name, {out_valid, out_valid3}, 0);
  endtask

  task automatic chk_fields(input string name, input logic [1:0] a, input logic [1:0] b,
                            input logic [3:0] m0, input logic [3:0] m1,
                            input logic gt, input logic hi);
    chk({name, "_fld_a"}, fld_a, a);
    chk({name, "_fld_b"}, fld_b, b);
    chk({name, "_fld_m0"}, fld_m0, m0);
    chk({name, "_fld_m1"}, fld_m1, m1);
    chk({name, "_a_gt_b"}, a_gt_b, gt);
    chk({name, "_hi_nonzero"}, hi_nonzero, hi);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1;
    logic [3:0] pat;

    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 32'hFFFF_FFFF;
    out_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_data3   = 12'h0;
    out_ready3 = 1'b1;

    // 1. Reset hold with a word presented
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_nibble", out_nibble, 0);
      chk("rst_state", dbg_state, 0);
      chk_fields("rst", 0, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", out_valid, 0);
    @(posedge clk);
    #1;

    // 2. Single word, first nibble one cycle after accept, 8 in a row
    send_word(32'h0000_061E);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("single_stream_valid", out_valid, 1);
      if (i == 0) chk_fields("single", 2'd1, 2'd2, 4'h1, 4'hE, 0, 0);
    end
    @(negedge clk);
    chk("single_back_idle", dbg_state, 0);
    chk("single_idle_valid", out_valid, 0);
    chk_fields("single_hold", 2'd1, 2'd2, 4'h1, 4'hE, 0, 0);
    @(posedge clk);
    #1;

    // 3. Back-to-back: second word accepted on the last nibble of the first
    send_word(32'h1234_5678);
    t1 = acc_cyc;
    send_word(32'h0000_0B00);
    chk("b2b_accept_spacing", acc_cyc - t1, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_stream_valid", out_valid, 1);
      if (i == 0) chk_fields("b2b", 2'd2, 2'd3, 4'h0, 4'h0, 0, 0);
    end
    wait_idle("b2b_idle");
    @(posedge clk);
    #1;

    // 4. Backpressure with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    fork
      begin
        send_word(32'hA000_0C00);
        @(negedge clk);
        chk_fields("bp", 2'd3, 2'd0, 4'h0, 4'h0, 1, 1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = pat[3 - (i % 4)];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle("bp_idle");
    chk("bp_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // 5. Reset after three nibbles have been taken
    send_word(32'h1234_5678);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk_fields("midrst", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_silent", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // 6. Three-nibble instance
    send_word3(12'hE7F);
    @(negedge clk);
    chk("n3_fld_a", fld_a3, 2'd3);
    chk("n3_fld_b", fld_b3, 2'd2);
    chk("n3_fld_m0", fld_m0_3, 4'h7);
    chk("n3_fld_m1", fld_m1_3, 4'hF);
    chk("n3_a_gt_b", a_gt_b3, 1);
    chk("n3_hi_nonzero", hi_nonzero3, 0);
    wait_idle("n3_idle");
    chk("n3_drained", exp3_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
